// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing: position bus, blank, active-low syncs, line/frame strobes and a frame counter.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by SYNC_DELAY extra registers to line up with lagging renderer colour.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 1) begin : g_bad_config
    $error("vga_timing_gen: totals must fit 10-bit counters and SYNC_DELAY must be >= 1");
  end

  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       blank_next;
  logic       hs_next;
  logic       vs_next;
  logic       line_next;
  logic       frame_next;
  logic       hs_int;
  logic       vs_int;

  // Flags are decoded from the next position so, once registered, they sit
  // in the same cycle as the DrawX/DrawY they describe.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    hc_next = DrawX + 10'd1;
    vc_next = DrawY;
    if (DrawX == H_LAST) begin
      hc_next = '0;
      vc_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
    blank_next = (hc_next < H_VIS) && (vc_next < V_VIS);
    hs_next    = !((hc_next >= HS_START) && (hc_next < HS_END));
    vs_next    = !((vc_next >= VS_START) && (vc_next < VS_END));
    line_next  = (hc_next == '0);
    frame_next = (hc_next == '0) && (vc_next == '0);
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      hs_int      <= 1'b1;
      vs_int      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= hc_next;
      DrawY       <= vc_next;
      blank       <= blank_next;
      hs_int      <= hs_next;
      vs_int      <= vs_next;
      line_start  <= line_next;
      frame_start <= frame_next;
      frame_count <= frame_count + 8'(frame_next);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;

  // Shift chains toward the pins; the oldest sample sits in the top bit.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe <= SYNC_DELAY'({hs_pipe, hs_int});
      vs_pipe <= SYNC_DELAY'({vs_pipe, vs_int});
    end
  end

  assign hs = hs_pipe[SYNC_DELAY-1];
  assign vs = vs_pipe[SYNC_DELAY-1];
`else
  assign hs = hs_int;
  assign vs = vs_int;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Drives the DrawX/DrawY/blank bus that the sprite and background renderers consume, and drives the hs/vs pins toward the DAC/connector. It also emits line and frame strobes plus a frame counter, used by animation logic such as river scrolling.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch in clocks
H_SYNC, 96, horizontal sync width in clocks
H_BACK, 48, horizontal back porch in clocks
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch in lines
SYNC_DELAY, 1, extra hs/vs pipeline stages; used only when VGA_SYNC_DELAY_EN is defined

Ports:
vga_clk  input  1  pixel clock, 25 MHz
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current horizontal counter, 0..H_TOTAL-1
DrawY  output  10  current vertical counter, 0..V_TOTAL-1
blank  output  1  display enable; 1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE)
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
line_start  output  1  one-cycle pulse when DrawX==0
frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
frame_count  output  8  frames completed, wraps 255->0

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the vertical equivalent (default 525). Both counters are 10 bits; totals above 1024 are illegal.
- Reset is asynchronous while asserted. Reset values:
  - DrawX=0, DrawY=0, frame_count=0
  - blank=0, line_start=0, frame_start=0
  - hs=1, vs=1
  - all SYNC_DELAY stages = 1
- Horizontal counter: each posedge, hc increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: vc increments only on the hc wrap. At V_TOTAL-1 it wraps to 0, on the same edge hc wraps.
- DrawX=hc and DrawY=vc. Both are register outputs with no combinational path.
- blank, hs, vs, line_start and frame_start are registered. Each is computed from the next-state counter values so it is valid in the same cycle as the DrawX/DrawY it describes. There is zero skew between the position bus and these flags.
- hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC. Default: 656..751 inclusive.
- vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC. Default: lines 490..491. vs changes only on hc wrap edges.
- frame_count increments on the edge where both counters wrap to (0,0). It therefore reads N+1 in the same cycle frame_start is high.
- First edge after reset release:
  - counters go to (1,0)
  - blank=1, line_start=0, frame_start=0
  - the (0,0) pixel of the first frame is not displayed, and no frame_start is issued for that frame
  - the first frame_start occurs H_TOTAL*V_TOTAL clocks after release
- Reset asserted mid-frame returns every output to its reset value immediately. There is no partial-frame recovery; timing restarts from (0,0).
- Renderers sample DrawX/DrawY/blank and add one pipeline stage (ROM read on negedge, register on posedge). Their colour output therefore lags blank by one clock. Compensation is the optional feature below.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined: hs and vs each pass through SYNC_DELAY additional registers, reset to 1, before reaching the ports. This aligns the sync pins with renderer colour outputs that lag by SYNC_DELAY clocks. DrawX, DrawY, blank, line_start, frame_start and frame_count are not delayed.
- Undefined: hs/vs are aligned with DrawX/DrawY as specified above, and SYNC_DELAY is ignored.

Test Plan:
- Reset hold 5 clocks, then release, with no macro → all outputs at reset values during reset. After the first edge: DrawX=1, DrawY=0, blank=1, hs=1, vs=1.
- Run one full line → hs=0 exactly for DrawX 656..751 (96 clocks). blank=0 for DrawX 640..799. line_start high only at DrawX=0. Line period is 800 clocks.
- Run 2 frames → vs=0 exactly for DrawY 490..491 (1600 clocks). blank=0 for all of DrawY 480..524. frame_start period is 420000 clocks.
- Check frame_start timing → first frame_start at 420000 clocks after release, with frame_count=1 in that cycle.
- Check frame_count wrap → after 256 frames, frame_count=0 in the same cycle as frame_start.
- Assert reset at DrawX=700, DrawY=300 (mid-hsync) → hs=1, blank=0, DrawX=0, DrawY=0 immediately, with no clock edge needed. After release, the counter sequence restarts at (1,0).
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=1 → hs falls when DrawX=657 and rises when DrawX=752. blank timing is unchanged.
